sar_search_ctrl: RTL and testbench

//  Successive-approximation search controller: the initiator that drives an N-bit

---
 rtl/sar_search_ctrl_if.sv | 15 +
 rtl/sar_search_ctrl.sv | 111 +++++++++++
 tb/tb_sar_search_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: start/flag/result bundle between the search controller and its comparator side
interface sar_search_ctrl_if #(parameter int N = 16);
    logic         start;
    logic         less;
    logic         more;
    logic         equal;
    logic [N-1:0] trial;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic         found;
    logic         err;
    modport master (input start, less, more, equal, output trial, result, busy, done, found, err);
    modport slave  (output start, less, more, equal, input trial, result, busy, done, found, err);
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search driving an external Less/More/Equal comparator
module sar_search_ctrl #(
    parameter int N       = 16,
    parameter int CMP_LAT = 1
) (
    input logic              clk,
    input logic              rst,
    sar_search_ctrl_if.master bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(CMP_LAT + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, TEST, VERIFY} state_t;

    state_t        state, state_n;
    logic [N-1:0]  trial, trial_n, r, r_n, result, result_n, bit_k, r_upd;
    logic [KW-1:0] k, k_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          busy, busy_n, done, done_n, found, found_n, err, err_n;

    assign bus.trial  = trial;
    assign bus.result = result;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.found  = found;
    assign bus.err    = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            trial  <= '0;
            r      <= '0;
            k      <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            trial  <= trial_n;
            r      <= r_n;
            k      <= k_n;
            cnt    <= cnt_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
            found  <= found_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        trial_n  = trial;
        r_n      = r;
        k_n      = k;
        cnt_n    = cnt;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;
        found_n  = found;
        err_n    = err;
        bit_k    = ONE << k;
        r_upd    = bus.less ? (r | bit_k) : r;
        if (state == IDLE) begin
            trial_n = '0;
            busy_n  = 1'b0;
            if (bus.start) begin
                state_n = TEST;
                trial_n = MSB;
                r_n     = '0;
                k_n     = KW'(N - 1);
                cnt_n   = '0;
                busy_n  = 1'b1;
                found_n = 1'b0;
                err_n   = 1'b0;
            end
        end else if (cnt != CW'(CMP_LAT - 1)) begin
            cnt_n = cnt + 1'b1;
        end else begin
            // Sample edge: every path below ends the search unless TEST keeps resolving bits
            cnt_n   = '0;
            state_n = IDLE;
            trial_n = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            if (!$onehot({bus.less, bus.more, bus.equal})) begin
                err_n    = 1'b1;
                found_n  = 1'b0;
                result_n = r;
            end else if (state == VERIFY) begin
                result_n = trial;
                found_n  = bus.equal;
            end else if (bus.equal) begin
                result_n = trial;
                found_n  = 1'b1;
            end else begin
                done_n  = 1'b0;
                busy_n  = 1'b1;
                state_n = (k == '0) ? VERIFY : TEST;
                r_n     = r_upd;
                k_n     = (k == '0) ? k : k - 1'b1;
                trial_n = (k == '0) ? r_upd : (r_upd | (bit_k >> 1));
            end
        end
    end
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: randomized and directed checks of the SAR search controller against a binary-search model
module tb_sar_search_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sar_search_ctrl_if #(.N(N)) b1 ();
    sar_search_ctrl_if #(.N(N)) b3 ();

    logic [7:0] tgt1 = 8'h00, tgt3 = 8'h00;
    logic       inj1 = 1'b0;

    // Ideal comparators; inj1 forces a non-one-hot flag pattern
    assign b1.less  = inj1 | (b1.trial < tgt1);
    assign b1.more  = inj1 | (b1.trial > tgt1);
    assign b1.equal = !inj1 && (b1.trial == tgt1);
    assign b3.less  = b3.trial < tgt3;
    assign b3.more  = b3.trial > tgt3;
    assign b3.equal = b3.trial == tgt3;

    sar_search_ctrl #(.N(N), .CMP_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
    sar_search_ctrl #(.N(N), .CMP_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.master));

    int n_cmp = 0, n_bad = 0;

    logic [7:0] exp_q[$], obs_q[$];
    int         exp_m, obs_c;
    logic [7:0] exp_res, obs_res;
    logic       exp_found, exp_err, obs_found, obs_err, obs_busy;

    // Reference: textbook binary search over trial values, with an optional corrupted step
    task automatic model(input logic [7:0] t, input int err_step);
        logic [7:0] r, tr;
        bit fin;
        r = 0; fin = 0;
        exp_q.delete(); exp_m = 0; exp_err = 0; exp_found = 0; exp_res = 0;
        for (int b = 7; b >= 0 && !fin; b--) begin
            tr = r + 8'(1 << b);
            exp_m++;
            exp_q.push_back(tr);
            if (exp_m == err_step) begin exp_err = 1; exp_res = r; fin = 1; end
            else if (tr == t) begin exp_found = 1; exp_res = tr; fin = 1; end
            else if (tr < t) r = tr;
        end
        if (!fin) begin
            exp_m++;
            exp_q.push_back(r);
            exp_res = r;
            if (exp_m == err_step) exp_err = 1;
            else exp_found = (r == t);
        end
    endtask

    // Drives one search on the latency-1 DUT and records what it observed
    task automatic run1(input logic [7:0] t, input int err_step, input int ign_c, input bit chain);
        obs_q.delete(); obs_c = -1;
        tgt1 = t; b1.start = 1; inj1 = 0;
        @(posedge clk);
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            b1.start = 0;
            if (b1.done) begin
                obs_c = c; obs_res = b1.result; obs_found = b1.found;
                obs_err = b1.err; obs_busy = b1.busy;
                inj1 = 0; b1.start = chain;
                break;
            end
            if (b1.busy) obs_q.push_back(b1.trial);
            inj1 = (c + 1 == err_step);
            b1.start = (c == ign_c);
        end
        inj1 = 0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({b1.trial, b1.result, b1.busy, b1.done, b1.found, b1.err} !== 20'h0) begin
            n_bad++; $display("FAIL reset_dut1 got %h want 0", {b1.trial, b1.result, b1.busy, b1.done, b1.found, b1.err});
        end
        n_cmp++;
        if ({b3.trial, b3.result, b3.busy, b3.done, b3.found, b3.err} !== 20'h0) begin
            n_bad++; $display("FAIL reset_dut3 got %h want 0", {b3.trial, b3.result, b3.busy, b3.done, b3.found, b3.err});
        end
    endtask

    task automatic test_directed();
        logic [7:0] tl[3] = '{8'hA5, 8'h00, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            model(tl[i], 0);
            run1(tl[i], 0, -1, 0);
            n_cmp++;
            if (obs_c !== exp_m) begin n_bad++; $display("FAIL dir_steps t=%h got %0d want %0d", tl[i], obs_c, exp_m); end
            n_cmp++;
            if (obs_q != exp_q) begin n_bad++; $display("FAIL dir_trials t=%h got %p want %p", tl[i], obs_q, exp_q); end
            n_cmp++;
            if ({obs_res, obs_found, obs_err, obs_busy} !== {tl[i], 1'b1, 1'b0, 1'b0}) begin
                n_bad++; $display("FAIL dir_result t=%h got %h/%b/%b/%b want %h/1/0/0", tl[i], obs_res, obs_found, obs_err, obs_busy, tl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        model(8'hFF, 0);
        run1(8'hFF, 0, -1, 1);
        n_cmp++;
        if (obs_c !== exp_m || obs_res !== 8'hFF) begin n_bad++; $display("FAIL b2b_first got %0d/%h want %0d/ff", obs_c, obs_res, exp_m); end
        model(8'h5A, 0);
        run1(8'h5A, 0, -1, 0);
        n_cmp++;
        if (obs_q.size() == 0 || obs_q[0] !== 8'h80) begin n_bad++; $display("FAIL b2b_restart got %p want 80 first", obs_q); end
        n_cmp++;
        if (obs_c !== exp_m || obs_q != exp_q || obs_res !== exp_res || obs_found !== exp_found) begin
            n_bad++; $display("FAIL b2b_second got %0d/%h/%b want %0d/%h/%b", obs_c, obs_res, obs_found, exp_m, exp_res, exp_found);
        end
    endtask

    task automatic test_latency3();
        logic [7:0] exp3[$], got3[$];
        int dc = -1;
        model(8'h3C, 0);
        foreach (exp_q[i]) repeat (3) exp3.push_back(exp_q[i]);
        tgt3 = 8'h3C; b3.start = 1;
        @(posedge clk);
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            b3.start = 0;
            if (b3.done) begin dc = c; break; end
            if (b3.busy) got3.push_back(b3.trial);
        end
        n_cmp++;
        if (dc !== 3 * exp_m) begin n_bad++; $display("FAIL lat3_steps got %0d want %0d", dc, 3 * exp_m); end
        n_cmp++;
        if (got3 != exp3) begin n_bad++; $display("FAIL lat3_trials got %p want %p", got3, exp3); end
        n_cmp++;
        if ({b3.result, b3.found, b3.err, b3.busy} !== {8'h3C, 3'b100}) begin
            n_bad++; $display("FAIL lat3_result got %h/%b/%b/%b want 3c/1/0/0", b3.result, b3.found, b3.err, b3.busy);
        end
    endtask

    task automatic test_error_and_ignore();
        model(8'hA5, 3);
        run1(8'hA5, 3, -1, 0);
        n_cmp++;
        if ({obs_c, obs_res, obs_found, obs_err} !== {exp_m, exp_res, 2'b01}) begin
            n_bad++; $display("FAIL err_step3 got %0d/%h/%b/%b want %0d/%h/0/1", obs_c, obs_res, obs_found, obs_err, exp_m, exp_res);
        end
        model(8'h71, 0);
        run1(8'h71, 0, 3, 0);
        n_cmp++;
        if (obs_c !== exp_m || obs_q != exp_q || obs_res !== 8'h71) begin
            n_bad++; $display("FAIL ignore_start got %0d/%p/%h want %0d/%p/71", obs_c, obs_q, obs_res, exp_m, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        tgt1 = 8'h9E; b1.start = 1;
        @(posedge clk);
        @(negedge clk); b1.start = 0;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if ({b1.trial, b1.result, b1.busy, b1.done, b1.found, b1.err} !== 20'h0) begin
            n_bad++; $display("FAIL rst_mid got %h want 0", {b1.trial, b1.result, b1.busy, b1.done, b1.found, b1.err});
        end
        rst = 0;
        repeat (12) begin @(negedge clk); dones += int'(b1.done) + int'(b1.busy); end
        n_cmp++;
        if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done got %0d want 0", dones); end
        model(8'h9E, 0);
        run1(8'h9E, 0, -1, 0);
        n_cmp++;
        if (obs_c !== exp_m || obs_q != exp_q || obs_res !== 8'h9E || obs_found !== 1'b1) begin
            n_bad++; $display("FAIL rst_then_search got %0d/%h/%b want %0d/9e/1", obs_c, obs_res, obs_found, exp_m);
        end
    endtask

    task automatic test_random();
        logic [7:0] t;
        int es;
        for (int i = 0; i < 25; i++) begin
            t  = 8'($urandom_range(0, 255));
            es = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
            model(t, es);
            run1(t, es, int'($urandom_range(0, 5)), 0);
            n_cmp++;
            if (obs_c !== exp_m || obs_q != exp_q || {obs_res, obs_found, obs_err, obs_busy} !== {exp_res, exp_found, exp_err, 1'b0}) begin
                n_bad++;
                $display("FAIL rand t=%h es=%0d got %0d/%h/%b/%b want %0d/%h/%b/%b", t, es, obs_c, obs_res, obs_found, obs_err, exp_m, exp_res, exp_found, exp_err);
            end
        end
    endtask

    initial begin
        b1.start = 0; b3.start = 0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 0;
        test_directed();
        test_back_to_back();
        test_latency3();
        test_error_and_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
